// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC operand sequencer slice:
//   - MAC_OP_W  : width of one MAC operand (a or b)
//   - MAC_ACC_W : width of the MAC accumulator / result
//   - seq_state_t : sequencer FSM states
// ---------------------------------------------------------------------------
package mac_pkg;

    localparam int MAC_OP_W  = 4;
    localparam int MAC_ACC_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/mac_op_fifo.sv
// ---------------------------------------------------------------------------
// mac_op_fifo
// Operand-pair buffer for the MAC sequencer.
//   MAC_SEQ_FIFO_EN defined   : circular FIFO of DEPTH entries (DEPTH a power
//                               of 2, >= 2); full when count == DEPTH.
//   MAC_SEQ_FIFO_EN undefined : single-entry holding register; full == valid.
// Ports:
//   clk, rst          clock, synchronous active-high reset (flushes buffer)
//   push, push_data   write one pair (caller guarantees !full)
//   pop               drop the head pair (caller guarantees !empty)
//   pop_data          head pair, valid whenever !empty
//   full, empty       occupancy flags
//   count             number of pairs held
// ---------------------------------------------------------------------------
module mac_op_fifo #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

`ifdef MAC_SEQ_FIFO_EN

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Storage carries no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;

`else

    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    // Push only happens while empty and pop only while full, so the two
    // never coincide in this variant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (push) begin
            r_valid <= 1'b1;
            r_data  <= push_data;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end

    assign pop_data = r_data;
    assign full     = r_valid;
    assign empty    = !r_valid;
    assign count    = CNT_W'(r_valid);

`endif

endmodule

// File: rtl/mac_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mac_operand_sequencer
// Operand-side controller for the MAC datapath. Buffers packed 4x4-bit operand
// pairs, and on start clears the MAC, issues exactly len pairs, waits out the
// MAC register latency, captures the accumulator and offers it on a
// valid/ready result port.
// Build option: MAC_SEQ_FIFO_EN selects a FIFO_DEPTH-entry operand FIFO;
// without it the buffer is a single-entry register.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, len                job request (sampled in IDLE only)
//   busy                      high in every state except IDLE
//   op_valid/op_data/op_ready operand pair stream, a=[3:0], b=[7:4]
//   mac_a, mac_b              registered operands to the MAC
//   mac_en, mac_clr           registered MAC accumulate / clear strobes
//   mac_acc                   MAC accumulator value
//   res_valid/res_data/res_ready  result stream
// ---------------------------------------------------------------------------
module mac_operand_sequencer
    import mac_pkg::*;
#(
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    input  logic                 op_valid,
    input  logic [7:0]           op_data,
    output logic                 op_ready,
    output logic [MAC_OP_W-1:0]  mac_a,
    output logic [MAC_OP_W-1:0]  mac_b,
    output logic                 mac_en,
    output logic                 mac_clr,
    input  logic [MAC_ACC_W-1:0] mac_acc,
    output logic                 res_valid,
    output logic [MAC_ACC_W-1:0] res_data,
    input  logic                 res_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    seq_state_t           r_state;
    logic [LEN_W-1:0]     r_remain;
    logic                 r_wait_cnt;
    logic [MAC_OP_W-1:0]  r_mac_a;
    logic [MAC_OP_W-1:0]  r_mac_b;
    logic                 r_mac_en;
    logic                 r_mac_clr;
    logic                 r_res_valid;
    logic [MAC_ACC_W-1:0] r_res_data;

    logic                 w_push;
    logic                 w_pop;
    logic [7:0]           w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [CNT_W-1:0]     w_count;
    logic                 w_unused_count;

    assign w_push = op_valid && op_ready;
    // Pop only in ISSUE with something buffered; an empty buffer is a stall.
    assign w_pop  = (r_state == ST_ISSUE) && !w_empty;

    mac_op_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_op_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (op_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Occupancy count is observation-only; the controller needs just the flags.
    assign w_unused_count = ^w_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remain    <= '0;
            r_wait_cnt  <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_en    <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            // Strobes are derived from the current state so they land in the
            // cycle after the deciding edge, matching the MAC's registered inputs.
            r_mac_en  <= w_pop;
            r_mac_clr <= (r_state == ST_CLEAR);
            if (w_pop) begin
                r_mac_a <= w_head[MAC_OP_W-1:0];
                r_mac_b <= w_head[2*MAC_OP_W-1:MAC_OP_W];
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remain <= len;
                        r_state  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_wait_cnt <= 1'b0;
                    r_state    <= (r_remain != '0) ? ST_ISSUE : ST_WAIT;
                end
                ST_ISSUE: begin
                    r_wait_cnt <= 1'b0;
                    if (w_pop) begin
                        r_remain <= r_remain - LEN_W'(1);
                        if (r_remain == LEN_W'(1)) begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // Two cycles: the last mac_en must reach the accumulator
                    // register before it is sampled.
                    if (r_wait_cnt) begin
                        r_res_data  <= mac_acc;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_wait_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (r_res_valid && res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign op_ready  = !w_full;
    assign mac_a     = r_mac_a;
    assign mac_b     = r_mac_b;
    assign mac_en    = r_mac_en;
    assign mac_clr   = r_mac_clr;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_operand_sequencer
// Self-checking bench: directed cases followed by randomized jobs. A queue of
// accepted pairs is the reference; each job's expected operands and result
// come from popping that queue and summing products modulo 256. A simple
// behavioural MAC closes the loop on mac_acc.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mac_operand_sequencer;

`ifdef MAC_SEQ_FIFO_EN
    localparam int TB_DEPTH = 4;
`else
    localparam int TB_DEPTH = 1;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       busy;
    logic       op_valid;
    logic [7:0] op_data;
    logic       op_ready;
    logic [3:0] mac_a;
    logic [3:0] mac_b;
    logic       mac_en;
    logic       mac_clr;
    logic [7:0] mac_acc;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         delay;
        logic [7:0] data;
    } feed_t;

    feed_t      feed_q[$];
    logic [7:0] model_q[$];

    mac_operand_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_en    (mac_en),
        .mac_clr   (mac_clr),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC on the far side of the sequencer.
    always_ff @(posedge clk) begin
        if (rst)          mac_acc <= 8'h00;
        else if (mac_clr) mac_acc <= 8'h00;
        else if (mac_en)  mac_acc <= mac_acc + ({4'b0, mac_a} * {4'b0, mac_b});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_pair(input int d, input logic [7:0] data);
        feed_t item;
        item.delay = d;
        item.data  = data;
        feed_q.push_back(item);
    endtask

    // Operand source: each queued item waits its delay once it is at the head,
    // then is offered until accepted. Accepted pairs go into the model queue.
    initial begin
        int    dly;
        logic  took;
        feed_t item;
        op_valid = 1'b0;
        op_data  = 8'h00;
        dly      = -1;
        took     = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (took) begin
                op_valid = 1'b0;
                took     = 1'b0;
            end
            if (!op_valid) begin
                if (dly < 0 && feed_q.size() > 0) dly = feed_q[0].delay;
                if (dly == 0 && feed_q.size() > 0) begin
                    item     = feed_q.pop_front();
                    op_valid = 1'b1;
                    op_data  = item.data;
                    dly      = -1;
                end else if (dly > 0) begin
                    dly--;
                end
            end
            @(negedge clk);
            if (op_valid && op_ready && !rst) begin
                model_q.push_back(op_data);
                took = 1'b1;
            end
        end
    end

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"},      busy,      0);
        chk({pfx, "_op_ready"},  op_ready,  1);
        chk({pfx, "_mac_a"},     mac_a,     0);
        chk({pfx, "_mac_b"},     mac_b,     0);
        chk({pfx, "_mac_en"},    mac_en,    0);
        chk({pfx, "_mac_clr"},   mac_clr,   0);
        chk({pfx, "_res_valid"}, res_valid, 0);
        chk({pfx, "_res_data"},  res_data,  0);
    endtask

    // Called just after a rising edge; holds reset across two edges.
    task automatic do_reset(input string pfx);
        rst = 1'b1;
        @(posedge clk); #1;
        model_q.delete();
        @(negedge clk);
        check_reset_outputs(pfx);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_loaded(input int k);
        int i;
        for (i = 0; i < 60 && model_q.size() < k; i++) begin
            @(posedge clk); #1;
        end
        chk("preload_timeout", (model_q.size() >= k), 1);
    endtask

    // Runs one job with start in cycle 0. exp_lat/exp_data < 0 mean "not fixed";
    // exp_gap > 0 requires that spacing between consecutive mac_en pulses.
    task automatic run_job(input int n, input int exp_lat, input int exp_data,
                           input int exp_gap, input int hold, input bit pulse_start);
        int         clr_cyc;
        int         en_cnt;
        int         last_en;
        int         res_cyc;
        int         sum;
        logic [7:0] p;
        bit         got_res;
        clr_cyc = -1; en_cnt = 0; last_en = -1; res_cyc = -1; sum = 0; got_res = 0;
        start = 1'b1;
        len   = 4'(n);
        for (int c = 0; c < 400 && !got_res; c++) begin
            @(negedge clk);
            if (c == 0) chk("busy_idle", busy, 0);
            if (c == 1) chk("busy_job", busy, 1);
            if (mac_en && mac_clr) chk("en_clr_excl", 1, 0);
            if (mac_clr) begin
                if (clr_cyc < 0) clr_cyc = c;
                else chk("clr_single", c, clr_cyc);
            end
            if (mac_en) begin
                if (model_q.size() == 0) begin
                    chk("model_underflow", 1, 0);
                end else begin
                    p = model_q.pop_front();
                    chk("mac_a", mac_a, p[3:0]);
                    chk("mac_b", mac_b, p[7:4]);
                    sum = sum + int'(p[3:0]) * int'(p[7:4]);
                end
                if (exp_gap > 0 && last_en >= 0) chk("en_gap", c - last_en, exp_gap);
                en_cnt++;
                last_en = c;
            end
            if (res_valid) begin
                got_res = 1;
                res_cyc = c;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (!got_res) begin
            chk("res_timeout", 0, 1);
            return;
        end
        chk("clr_cycle", clr_cyc, 2);
        chk("en_count", en_cnt, n);
        chk("res_cycle", res_cyc, (n == 0) ? 4 : last_en + 2);
        if (exp_lat >= 0) chk("res_latency", res_cyc, exp_lat);
        chk("res_data", res_data, sum & 255);
        if (exp_data >= 0) chk("res_const", res_data, exp_data);
        $display("job len=%0d res_cycle=%0d res_data=0x%02h model=0x%02h", n, res_cyc, res_data, sum & 255);
        for (int h = 0; h < hold; h++) begin
            start = (pulse_start && h == 1);
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, sum & 255);
            @(posedge clk); #1;
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("hs_valid", res_valid, 1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_valid", res_valid, 0);
        chk("post_hs_busy", busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        len       = 4'd0;
        res_ready = 1'b0;
        #1;
        do_reset("init");

        // (3,5), (15,15), (2,7) -> 15 + 225 + 14 = 254
        push_pair(0, 8'h53);
        push_pair(0, 8'hFF);
        push_pair(0, 8'h72);
        wait_loaded((TB_DEPTH < 3) ? TB_DEPTH : 3);
        run_job(3, (TB_DEPTH >= 3) ? 7 : -1, 8'hFE, 0, 0, 1'b0);

        // 2 * 225 = 450 -> 194 modulo 256
        push_pair(0, 8'hFF);
        push_pair(0, 8'hFF);
        run_job(2, -1, 8'hC2, 0, 0, 1'b0);

        run_job(0, 4, 8'h00, 0, 0, 1'b0);

        // Pairs offered 3 cycles apart; result held under backpressure while
        // a stray start pulse arrives in DONE.
        push_pair(5, 8'h21);
        push_pair(2, 8'h94);
        push_pair(2, 8'hE7);
        push_pair(2, 8'h5B);
        run_job(4, -1, -1, 3, 5, 1'b1);

        // Fill the buffer in IDLE, then reset mid-ISSUE.
        for (int i = 0; i <= TB_DEPTH; i++) push_pair(0, 8'(8'h31 + 8'(i * 17)));
        wait_loaded(TB_DEPTH);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_op_ready", op_ready, 0);
            chk("full_held", model_q.size(), TB_DEPTH);
            @(posedge clk); #1;
        end
        start = 1'b1;
        len   = 4'(TB_DEPTH);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        do_reset("midjob");

        for (int j = 0; j < 25; j++) begin
            int n;
            int extra;
            n     = $urandom_range(0, 6);
            extra = $urandom_range(0, 1);
            for (int k = 0; k < n + extra; k++) push_pair($urandom_range(0, 3), 8'($urandom));
            run_job(n, -1, -1, 0, $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
